// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 4-digit BCD scan controller with shadow/active digit registers
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shows).
module seg_scan_ctrl #(
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_TICKS     = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN,
  input  logic       WR_REQ,
  input  logic [1:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  input  logic       COMMIT,
  output logic       WR_ACK,
  output logic       PENDING,
  output logic [9:0] DIGIT_OH,
  output logic [3:0] AN,
  output logic       FRAME
);

  // One counter serves both SHOW and BLANK, so it must hold the larger terminal count.
  localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {st_off, st_show, st_blank} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] tick;
  logic [1:0]    idx;
  logic [3:0]    shadow [4];
  logic [3:0]    active [4];
  logic [3:0]    cur;
  logic [3:0]    lz_dark;
  logic          copy;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= st_off;
    else       state <= state_nx;
  end

  // Next-state: EN low abandons whatever is showing; otherwise SHOW/BLANK alternate on terminal count.
  always_comb begin
    state_nx = state;
    if (!EN) begin
      state_nx = st_off;
    end else begin
      case (state)
        st_off:   state_nx = st_show;
        st_show:  if (tick == SHOW_LAST)  state_nx = st_blank;
        st_blank: if (tick == BLANK_LAST) state_nx = st_show;
        default:  state_nx = st_off;
      endcase
    end
  end

  // Tick counter and digit index; idx advances only when a BLANK interval ends, wrapping 3->0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tick <= '0;
      idx  <= 2'd0;
    end else if (!EN || state == st_off) begin
      tick <= '0;
      idx  <= 2'd0;
    end else if (state == st_show) begin
      tick <= (tick == SHOW_LAST) ? '0 : tick + CW'(1);
    end else if (tick == BLANK_LAST) begin
      tick <= '0;
      idx  <= idx + 2'd1;
    end else begin
      tick <= tick + CW'(1);
    end
  end

  // A pending commit lands on the frame boundary, or immediately while the scan is off.
  assign copy = PENDING && (FRAME || state == st_off);

  // Shadow/active digit storage, commit flag and write acknowledge. Non-blocking updates give
  // the copy the pre-write shadow when a write and a copy share an edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
      PENDING <= 1'b0;
      WR_ACK  <= 1'b0;
    end else begin
      WR_ACK <= WR_REQ;
      if (WR_REQ) shadow[WR_ADDR] <= WR_DATA;
      if (copy) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
      end
      if (COMMIT)    PENDING <= 1'b1;
      else if (copy) PENDING <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz_dark    = 4'b0000;
    lz_dark[3] = (active[3] == 4'd0);
    lz_dark[2] = lz_dark[3] && (active[2] == 4'd0);
    lz_dark[1] = lz_dark[2] && (active[1] == 4'd0);
  end
`else
  // Every digit displays its value.
  always_comb begin
    lz_dark = 4'b0000;
  end
`endif

  assign cur = active[idx];

  // Output decode: digit select and one-hot value only in SHOW; non-BCD values stay dark.
  always_comb begin
    AN       = 4'b1111;
    DIGIT_OH = 10'd0;
    FRAME    = 1'b0;
    case (state)
      st_show: begin
        AN[idx] = 1'b0;
        if (cur <= 4'd9 && !lz_dark[idx]) DIGIT_OH = 10'd1 << cur;
      end
      st_blank: FRAME = (tick == BLANK_LAST) && (idx == 2'd3);
      default: ;
    endcase
  end

endmodule
